// File: rtl/fpdiv_nr_sequencer.sv
// Multi-cycle single-precision divider controller.
// Forms A/B as A * (1/B), where 1/B is refined by Newton-Raphson from a
// linear seed, time-sharing one external combinational fp multiplier and
// one external fp adder (one operation per cycle). Special operands are
// resolved in a single classification cycle and skip the iteration.
module fpdiv_nr_sequencer #(
    parameter int NR_ITERS = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] InputA,
    input  logic [31:0] InputB,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] AbyB,
    output logic [1:0]  EXCEPTION,
    output logic [31:0] MUL_A,
    output logic [31:0] MUL_B,
    input  logic [31:0] MUL_OUT,
    output logic [31:0] ADD_A,
    output logic [31:0] ADD_B,
    input  logic [31:0] ADD_OUT
);

    // Linear seed 48/17 - 32/17*D minimises the worst-case seed error (1/17) on [0.5,1)
    localparam logic [31:0] SEED_SLOPE = 32'h3FF0F0F1;
    localparam logic [31:0] SEED_BIAS  = 32'h4034B4B5;
    localparam logic [31:0] FP_TWO     = 32'h40000000;
    localparam logic [31:0] QNAN       = 32'h7FC00000;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_DIV0    = 2'b01;
    localparam logic [1:0] EXC_INVALID = 2'b10;
    localparam logic [1:0] EXC_RANGE   = 2'b11;

    localparam logic [1:0] LAST_ITER = 2'(NR_ITERS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_SEED_MUL,
        S_SEED_ADD,
        S_IT_MUL1,
        S_IT_ADD,
        S_IT_MUL2,
        S_FINAL,
        S_FIN
    } state_t;

    state_t      state, state_next;

    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic [31:0] d_reg, d_next;
    logic [31:0] t_reg, t_next;
    logic [31:0] n_reg, n_next;
    logic [31:0] quot_reg, quot_next;
    logic [1:0]  exc_reg, exc_next;
    logic [1:0]  iter_cnt, iter_next;

    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic        q_sign;
    logic signed [9:0] recip_exp;
    logic signed [9:0] prod_exp;
    logic [31:0] recip;

    function automatic logic [31:0] signed_inf(input logic sign);
        return {sign, 8'hFF, 23'd0};
    endfunction

    function automatic logic [31:0] signed_zero(input logic sign);
        return {sign, 31'd0};
    endfunction

    // Subtraction is done on the shared adder by flipping the sign bit
    function automatic logic [31:0] negate(input logic [31:0] x);
        return {~x[31], x[30:0]};
    endfunction

    // Denormals are flushed: a zero exponent field counts as zero
    assign a_zero = (a_reg[30:23] == 8'h00);
    assign a_inf  = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] == 23'd0);
    assign a_nan  = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] != 23'd0);
    assign b_zero = (b_reg[30:23] == 8'h00);
    assign b_inf  = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] == 23'd0);
    assign b_nan  = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] != 23'd0);
    assign q_sign = a_reg[31] ^ b_reg[31];

    // N approximates 1/D with D = mantB scaled into [0.5,1), so 1/B = N * 2^(126-expB)
    assign recip_exp = $signed({2'b00, n_reg[30:23]}) + 10'sd126 - $signed({2'b00, b_reg[30:23]});
    assign prod_exp  = $signed({2'b00, a_reg[30:23]}) + recip_exp - 10'sd127;
    assign recip     = {b_reg[31], recip_exp[7:0], n_reg[22:0]};

    assign AbyB      = quot_reg;
    assign EXCEPTION = exc_reg;

    // Next-state, shared-unit operand steering and datapath register updates
    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        d_next     = d_reg;
        t_next     = t_reg;
        n_next     = n_reg;
        quot_next  = quot_reg;
        exc_next   = exc_reg;
        iter_next  = iter_cnt;
        MUL_A      = 32'd0;
        MUL_B      = 32'd0;
        ADD_A      = 32'd0;
        ADD_B      = 32'd0;
        BUSY       = (state != S_IDLE);
        DONE       = (state == S_FIN);

        case (state)
            S_IDLE: begin
                if (START) begin
                    a_next     = InputA;
                    b_next     = InputB;
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                state_next = S_FIN;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    quot_next = QNAN;
                    exc_next  = EXC_INVALID;
                end else if (b_zero && !a_inf) begin
                    quot_next = signed_inf(q_sign);
                    exc_next  = EXC_DIV0;
                end else if (a_zero || b_inf) begin
                    quot_next = signed_zero(q_sign);
                    exc_next  = EXC_NONE;
                end else if (a_inf) begin
                    quot_next = signed_inf(q_sign);
                    exc_next  = EXC_NONE;
                end else begin
                    d_next     = {1'b0, 8'h7E, b_reg[22:0]};
                    state_next = S_SEED_MUL;
                end
            end
            S_SEED_MUL: begin
                MUL_A      = SEED_SLOPE;
                MUL_B      = d_reg;
                t_next     = MUL_OUT;
                state_next = S_SEED_ADD;
            end
            S_SEED_ADD: begin
                ADD_A      = SEED_BIAS;
                ADD_B      = negate(t_reg);
                n_next     = ADD_OUT;
                state_next = S_IT_MUL1;
            end
            S_IT_MUL1: begin
                MUL_A      = d_reg;
                MUL_B      = n_reg;
                t_next     = MUL_OUT;
                state_next = S_IT_ADD;
            end
            S_IT_ADD: begin
                ADD_A      = FP_TWO;
                ADD_B      = negate(t_reg);
                t_next     = ADD_OUT;
                state_next = S_IT_MUL2;
            end
            S_IT_MUL2: begin
                MUL_A  = n_reg;
                MUL_B  = t_reg;
                n_next = MUL_OUT;
                if (iter_cnt == LAST_ITER) begin
                    iter_next  = 2'd0;
                    state_next = S_FINAL;
                end else begin
                    iter_next  = iter_cnt + 2'd1;
                    state_next = S_IT_MUL1;
                end
            end
            S_FINAL: begin
                state_next = S_FIN;
                if (recip_exp < 10'sd1) begin
                    quot_next = signed_zero(q_sign);
                    exc_next  = EXC_RANGE;
                end else if (recip_exp > 10'sd254) begin
                    quot_next = signed_inf(q_sign);
                    exc_next  = EXC_RANGE;
                end else begin
                    MUL_A = a_reg;
                    MUL_B = recip;
                    // prod_exp ignores the mantissa carry; the unit's own exponent covers that edge
                    if ((prod_exp > 10'sd254) || (MUL_OUT[30:23] == 8'hFF)) begin
                        quot_next = signed_inf(q_sign);
                        exc_next  = EXC_RANGE;
                    end else if ((prod_exp < 10'sd0) || (MUL_OUT[30:23] == 8'h00)) begin
                        quot_next = signed_zero(q_sign);
                        exc_next  = EXC_RANGE;
                    end else begin
                        quot_next = MUL_OUT;
                        exc_next  = EXC_NONE;
                    end
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= S_IDLE;
            a_reg    <= 32'd0;
            b_reg    <= 32'd0;
            d_reg    <= 32'd0;
            t_reg    <= 32'd0;
            n_reg    <= 32'd0;
            quot_reg <= 32'd0;
            exc_reg  <= 2'b00;
            iter_cnt <= 2'd0;
        end else begin
            state    <= state_next;
            a_reg    <= a_next;
            b_reg    <= b_next;
            d_reg    <= d_next;
            t_reg    <= t_next;
            n_reg    <= n_next;
            quot_reg <= quot_next;
            exc_reg  <= exc_next;
            iter_cnt <= iter_next;
        end
    end

endmodule

// File: tb/tb_fpdiv_nr_sequencer.sv
// Scoreboard bench for fpdiv_nr_sequencer: provides truncating fp
// multiplier/adder models for the shared units, issues directed and random
// divisions, and checks results, exception codes, latency and BUSY.
module tb_fpdiv_nr_sequencer;

    localparam int NR_ITERS = 2;
    localparam int LAT_FULL = 5 + 3 * NR_ITERS;
    localparam int LAT_FAST = 2;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        START;
    logic [31:0] InputA, InputB;
    logic        BUSY, DONE;
    logic [31:0] AbyB;
    logic [1:0]  EXCEPTION;
    logic [31:0] MUL_A, MUL_B, MUL_OUT;
    logic [31:0] ADD_A, ADD_B, ADD_OUT;

    always #5 CLOCK = ~CLOCK;

    fpdiv_nr_sequencer #(.NR_ITERS(NR_ITERS)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START),
        .InputA(InputA), .InputB(InputB),
        .BUSY(BUSY), .DONE(DONE), .AbyB(AbyB), .EXCEPTION(EXCEPTION),
        .MUL_A(MUL_A), .MUL_B(MUL_B), .MUL_OUT(MUL_OUT),
        .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_OUT(ADD_OUT)
    );

    // Single-precision bits to real (zero exponent field reads as zero)
    function automatic real f2r(input logic [31:0] x);
        logic [10:0] e11;
        if (x[30:23] == 8'h00) return 0.0;
        e11 = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e11, x[22:0], 29'd0});
    endfunction

    // Real to single-precision bits, truncating, flushing tiny values, saturating huge ones
    function automatic logic [31:0] r2f(input real v);
        logic [63:0] d;
        int          e;
        d = $realtobits(v);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = int'({21'd0, d[62:52]}) - 896;
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // The external shared units
    assign MUL_OUT = r2f(f2r(MUL_A) * f2r(MUL_B));
    assign ADD_OUT = r2f(f2r(ADD_A) + f2r(ADD_B));

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] bits;
        logic [1:0]  exc;
        logic        approx;
        logic [63:0] qbits;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int  tests = 0;
    int  fails = 0;
    int  edge_cnt = 0;
    real tol;

    always @(posedge CLOCK) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Reference: classification rules, then the exact quotient in double precision
    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b, input int acc);
        exp_t e;
        logic az, ai, an, bz, bi, bn, s;
        real  q, mag;
        az = (a[30:23] == 8'h00);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bz = (b[30:23] == 8'h00);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        s  = a[31] ^ b[31];
        e = '0;
        e.a = a;
        e.b = b;
        e.acc = acc;
        e.lat = LAT_FAST;
        if (an || bn || (az && bz) || (ai && bi)) begin
            e.bits = 32'h7FC00000; e.exc = 2'b10;
        end else if (bz && !ai) begin
            e.bits = {s, 31'h7F800000}; e.exc = 2'b01;
        end else if (az || bi) begin
            e.bits = {s, 31'd0}; e.exc = 2'b00;
        end else if (ai) begin
            e.bits = {s, 31'h7F800000}; e.exc = 2'b00;
        end else begin
            e.lat = LAT_FULL;
            q = f2r(a) / f2r(b);
            mag = (q < 0.0) ? -q : q;
            if (mag >= 3.402823669209385e38) begin
                e.bits = {s, 31'h7F800000}; e.exc = 2'b11;
            end else if (mag < 1.1754943508222875e-38) begin
                e.bits = {s, 31'd0}; e.exc = 2'b11;
            end else begin
                e.approx = 1'b1;
                e.qbits = $realtobits(q);
            end
        end
        return e;
    endfunction

    // Called just after a rising edge; raises START once the DUT is idle
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        while (BUSY !== 1'b0 && waited < 100) begin
            @(posedge CLOCK); #1;
            waited++;
        end
        if (BUSY !== 1'b0) begin
            tests++; fails++;
            $display("FAIL idle_wait: BUSY still %b after %0d cycles, required 0", BUSY, waited);
        end
        START = 1'b1;
        InputA = a;
        InputB = b;
        sb.push_back(ref_div(a, b, edge_cnt + 1));
        @(posedge CLOCK); #1;
        START = 1'b0;
        InputA = $urandom;
        InputB = $urandom;
    endtask

    // Extra START pulse with junk operands while an operation is running
    task automatic stray_start();
        START = 1'b1;
        InputA = $urandom;
        InputB = $urandom;
        @(posedge CLOCK); #1;
        START = 1'b0;
    endtask

    function automatic logic [31:0] rand_normal();
        logic [31:0] x;
        x[31]    = 1'($urandom);
        x[30:23] = 8'($urandom_range(80, 175));
        x[22:0]  = 23'($urandom);
        return x;
    endfunction

    // Monitor: BUSY/operand checks every cycle, result/latency checks on DONE
    initial begin
        exp_t e;
        int   cyc;
        logic exp_busy;
        real  q, g, err;
        forever begin
            @(negedge CLOCK);
            if (RESET !== 1'b1) begin
                cyc = 0;
                exp_busy = 1'b0;
                if (sb.size() > 0) begin
                    cyc = edge_cnt - sb[0].acc + 1;
                    exp_busy = (cyc >= 1);
                end
                check_eq("busy", {31'd0, BUSY}, {31'd0, exp_busy});
                if (BUSY === 1'b0)
                    check_eq("idle_operands", MUL_A | MUL_B | ADD_A | ADD_B, 32'd0);
                if (DONE === 1'b1) begin
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_done: DONE=1 with AbyB %h, required no DONE", AbyB);
                    end else begin
                        e = sb.pop_front();
                        check_eq("done_cycle", 32'(cyc), 32'(e.lat));
                        if (!e.approx) begin
                            check_eq("quotient", AbyB, e.bits);
                            check_eq("exception", {30'd0, EXCEPTION}, {30'd0, e.exc});
                        end else begin
                            q = $bitstoreal(e.qbits);
                            g = f2r(AbyB);
                            err = (g - q) / q;
                            if (err < 0.0) err = -err;
                            tests++;
                            if (EXCEPTION !== 2'b00 || AbyB[30:23] == 8'h00 ||
                                AbyB[30:23] == 8'hFF || err > tol) begin
                                fails++;
                                $display("FAIL quotient_approx %h/%h: got %h exc %b, required about %h exc 00 (rel err %g > %g)",
                                         e.a, e.b, AbyB, EXCEPTION, r2f(q), err, tol);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] dir_a [18];
    logic [31:0] dir_b [18];
    logic [31:0] specials [6];

    initial begin
        real e1;
        logic [31:0] a, b;
        int  w;

        // Linear seed error 1/17 squares each iteration; allow a few ulp for truncating units
        e1 = 1.0 / 17.0;
        for (int i = 0; i < NR_ITERS; i++) e1 = e1 * e1;
        tol = e1 * 1.05 + 1.0 / 524288.0;

        dir_a = '{32'h40C00000, 32'hC0F00000, 32'h3F800000, 32'h00000000, 32'h7FC00000, 32'hBF800000,
                  32'h7F800000, 32'h40000000, 32'h00000000, 32'h7F800000, 32'h7F800000, 32'h80000000,
                  32'h7E800000, 32'h3F800000, 32'h0D800000, 32'h3F800000, 32'h00400000, 32'h40A00000};
        dir_b = '{32'h40400000, 32'h40200000, 32'h00000000, 32'h00000000, 32'h3F800000, 32'h00000000,
                  32'h40000000, 32'h7F800000, 32'h40A00000, 32'h00000000, 32'hFF800000, 32'hC0400000,
                  32'h0D800000, 32'h7F000000, 32'h71800000, 32'h40400000, 32'h3F800000, 32'hC0E00000};
        specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F812345};

        RESET = 1'b1;
        START = 1'b0;
        InputA = 32'd0;
        InputB = 32'd0;
        repeat (3) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        check_eq("reset_busy", {31'd0, BUSY}, 32'd0);
        check_eq("reset_done", {31'd0, DONE}, 32'd0);
        check_eq("reset_quotient", AbyB, 32'd0);
        check_eq("reset_exception", {30'd0, EXCEPTION}, 32'd0);
        check_eq("reset_mul_operands", MUL_A | MUL_B, 32'd0);
        check_eq("reset_add_operands", ADD_A | ADD_B, 32'd0);

        for (int i = 0; i < 18; i++) issue(dir_a[i], dir_b[i]);

        // START pulses at cycles 3 and 7 are ignored; the next one in cycle 12 is taken
        issue(32'h40C00000, 32'h40400000);
        repeat (2) begin @(posedge CLOCK); #1; end
        stray_start();
        repeat (3) begin @(posedge CLOCK); #1; end
        stray_start();
        issue(32'h3F800000, 32'h40800000);

        // RESET in cycle 5 aborts without DONE
        issue(32'h40C00000, 32'h40400000);
        repeat (4) begin @(posedge CLOCK); #1; end
        RESET = 1'b1;
        sb.delete();
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        check_eq("abort_busy", {31'd0, BUSY}, 32'd0);
        check_eq("abort_done", {31'd0, DONE}, 32'd0);
        check_eq("abort_quotient", AbyB, 32'd0);
        check_eq("abort_exception", {30'd0, EXCEPTION}, 32'd0);
        issue(32'h3F800000, 32'h40800000);

        for (int i = 0; i < 40; i++) begin
            a = rand_normal();
            b = rand_normal();
            if ($urandom_range(0, 7) == 0) a = specials[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) b = specials[$urandom_range(0, 5)];
            repeat ($urandom_range(0, 2)) begin @(posedge CLOCK); #1; end
            issue(a, b);
        end

        w = 0;
        while (sb.size() > 0 && w < 200) begin
            @(posedge CLOCK); #1;
            w++;
        end
        if (sb.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d results still outstanding, required 0", sb.size());
        end
        repeat (2) @(posedge CLOCK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
